// File: rtl/gpio_port_if.sv
// Register-bus interface for gpio_port: word index, write data, strobes and
// registered read data.
interface gpio_port_if;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output we,
    output re,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    input  re,
    output rdata
  );
endinterface

// File: rtl/gpio_port.sv
// Memory-mapped GPIO: synchronised inputs, atomic set/clear outputs and
// per-bit rising/falling edge capture into a W1C status register with irq.
module gpio_port #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset,
  gpio_port_if.slave       bus,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_IN      = 3'd0,
    REG_OUT     = 3'd1,
    REG_OUT_SET = 3'd2,
    REG_OUT_CLR = 3'd3,
    REG_RISE_EN = 3'd4,
    REG_FALL_EN = 3'd5,
    REG_STATUS  = 3'd6,
    REG_RSVD    = 3'd7
  } reg_addr_e;

  reg_addr_e        addr_e;
  logic [WIDTH-1:0] wr_val;
  logic             unused_wdata_bits;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] in_val;

  logic [WIDTH-1:0] o_q, o_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rd_mux;

  assign addr_e            = reg_addr_e'(bus.addr);
  assign wr_val            = bus.wdata[WIDTH-1:0];
  // Bits of wdata above WIDTH carry no meaning for this port.
  assign unused_wdata_bits = ^bus.wdata;

  assign in_val = sync_q[SYNC_STAGES-1];
  assign rise   = in_val & ~prev_q & rise_en_q;
  assign fall   = ~in_val & prev_q & fall_en_q;

  // Write decode and next-state for the software-visible registers.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    o_d       = o_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    if (bus.we) begin
      unique case (addr_e)
        REG_OUT:     o_d       = wr_val;
        REG_OUT_SET: o_d       = o_q | wr_val;
        REG_OUT_CLR: o_d       = o_q & ~wr_val;
        REG_RISE_EN: rise_en_d = wr_val;
        REG_FALL_EN: fall_en_d = wr_val;
        REG_STATUS:  clr       = wr_val;
        default:     ;
      endcase
    end
    // A fresh edge beats a W1C of the same bit in the same cycle.
    status_d = (status_q & ~clr) | rise | fall;
  end

  // Read mux samples pre-write state, so a same-cycle write+read of one
  // register returns the old value.
  always_comb begin
    rd_mux = '0;
    unique case (addr_e)
      REG_IN:      rd_mux = in_val;
      REG_OUT:     rd_mux = o_q;
      REG_RISE_EN: rd_mux = rise_en_q;
      REG_FALL_EN: rd_mux = fall_en_q;
      REG_STATUS:  rd_mux = status_q;
      default:     rd_mux = '0;
    endcase
    rdata_d = bus.re ? 32'(rd_mux) : rdata_q;
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the synchroniser chain is reset too, so a stale pre-reset input
      // cannot appear as an edge right after reset is released.
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q    <= '0;
      o_q       <= OUT_RESET[WIDTH-1:0];
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
    end else begin
      sync_q[0] <= i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q    <= in_val;
      o_q       <= o_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o         = o_q;
  assign irq       = |status_q;
  assign bus.rdata = rdata_q;

endmodule
